// File: rtl/bcd_div3_scheduler_if.sv
// Requester and result handshake bundle for bcd_div3_scheduler.
interface bcd_div3_scheduler_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  logic                    req0;
  logic [4*NUM_DIGITS-1:0] din0;
  logic                    ack0;
  logic                    req1;
  logic [4*NUM_DIGITS-1:0] din1;
  logic                    ack1;
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_div3;
  logic                    res_invalid;
  logic                    res_id;

  // Requesters and result consumer
  modport master (
    output req0, din0, req1, din1, res_ready,
    input  ack0, ack1, res_valid, res_div3, res_invalid, res_id
  );

  // Scheduler side
  modport slave (
    input  req0, din0, req1, din1, res_ready,
    output ack0, ack1, res_valid, res_div3, res_invalid, res_id
  );
endinterface

// File: rtl/bcd_div3_scheduler.sv
// Two-requester round-robin front end with a serial BCD mod-3 engine.
// One digit is folded per cycle, LSD first; the result is held until accepted.
module bcd_div3_scheduler #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_div3_scheduler_if.slave     bus,
  output logic                    busy
);

  localparam int unsigned W    = 4 * NUM_DIGITS;
  localparam int unsigned CntW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [1:0]      residue_q, residue_d;
  logic            invalid_q, invalid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            res_valid_q, res_valid_d;
  logic            res_div3_q, res_div3_d;
  logic            res_invalid_q, res_invalid_d;
  logic            res_id_q, res_id_d;
  logic            last_q, last_d;  // id of last accepted grant
  logic            busy_q, busy_d;

  logic [3:0]      digit;
  logic [1:0]      dig_mod3;
  logic [2:0]      sum;
  logic            grant1;

  assign digit = shreg_q[3:0];

  // Digit mod 3 lookup, defined for all 16 nibble values
  always_comb begin
    dig_mod3 = 2'd0;
    unique case (digit)
      4'd1, 4'd4, 4'd7, 4'd10, 4'd13: dig_mod3 = 2'd1;
      4'd2, 4'd5, 4'd8, 4'd11, 4'd14: dig_mod3 = 2'd2;
      default:                        dig_mod3 = 2'd0;
    endcase
  end

  // Next-state and output logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    residue_d     = residue_q;
    invalid_d     = invalid_q;
    cnt_d         = cnt_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    res_valid_d   = res_valid_q;
    res_div3_d    = res_div3_q;
    res_invalid_d = res_invalid_q;
    res_id_d      = res_id_q;
    last_d        = last_q;
    grant1        = 1'b0;
    sum           = {1'b0, residue_q} + {1'b0, dig_mod3};

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // Requester 1 wins alone, or on contention when 0 held the last grant
          grant1    = bus.req1 & (~bus.req0 | ~last_q);
          shreg_d   = grant1 ? bus.din1 : bus.din0;
          residue_d = 2'd0;
          invalid_d = 1'b0;
          cnt_d     = '0;
          res_id_d  = grant1;
          ack0_d    = ~grant1;
          ack1_d    = grant1;
          state_d   = StRun;
        end
      end
      StRun: begin
        unique case (sum)
          3'd1, 3'd4: residue_d = 2'd1;
          3'd2:       residue_d = 2'd2;
          default:    residue_d = 2'd0;
        endcase
        invalid_d = invalid_q | (digit > 4'd9);
        shreg_d   = shreg_q >> 4;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cnt_d         = '0;
          res_valid_d   = 1'b1;
          res_div3_d    = (residue_d == 2'd0) & ~invalid_d;
          res_invalid_d = invalid_d;
          state_d       = StDone;
        end
      end
      StDone: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          last_d      = res_id_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State registers; reset leaves requester 0 with priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      residue_q     <= 2'd0;
      invalid_q     <= 1'b0;
      cnt_q         <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_div3_q    <= 1'b0;
      res_invalid_q <= 1'b0;
      res_id_q      <= 1'b0;
      last_q        <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      residue_q     <= residue_d;
      invalid_q     <= invalid_d;
      cnt_q         <= cnt_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      res_valid_q   <= res_valid_d;
      res_div3_q    <= res_div3_d;
      res_invalid_q <= res_invalid_d;
      res_id_q      <= res_id_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_div3    = res_div3_q;
  assign bus.res_invalid = res_invalid_q;
  assign bus.res_id      = res_id_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_bcd_div3_scheduler.sv
// Directed self-checking bench for bcd_div3_scheduler (NUM_DIGITS = 4).
module tb_bcd_div3_scheduler;
  localparam int unsigned ND = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_div3_scheduler_if #(.NUM_DIGITS(ND)) bus ();

  bcd_div3_scheduler #(.NUM_DIGITS(ND)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic raise(input int which, input logic [15:0] d);
    if (which == 0) begin bus.req0 = 1'b1; bus.din0 = d; end
    else            begin bus.req1 = 1'b1; bus.din1 = d; end
  endtask

  task automatic drop(input int which);
    if (which == 0) bus.req0 = 1'b0;
    else            bus.req1 = 1'b0;
  endtask

  // Negedges until the requester's ack is seen (-1 on timeout); drops req on ack
  task automatic wait_ack(input int which, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.ack0 === 1'b1) || (which == 1 && bus.ack1 === 1'b1)) begin
        cyc = i;
        drop(which);
        break;
      end
    end
  endtask

  // Negedges until res_valid is seen (-1 on timeout)
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {bus.ack0, bus.ack1, bus.res_valid, bus.res_div3, bus.res_invalid, bus.res_id, busy};
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 7'b0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int ca, cv;
    raise(0, 16'h1234);
    wait_ack(0, ca);
    n_checks++;
    if (ca !== 1) begin n_fail++; $display("FAIL single_ack_cycle: got %0d expected 1", ca); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++;
    if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 0", bus.ack0); end
    wait_valid(cv);
    n_checks++;
    if (cv !== 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", cv); end
    n_checks++;
    if ({bus.res_div3, bus.res_invalid, bus.res_id} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_result: got %b expected 000", {bus.res_div3, bus.res_invalid, bus.res_id});
    end
    accept();
    n_checks++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_accept: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_max_value();
    logic [15:0] vec [2] = '{16'h9999, 16'h0000};
    int ca, cv;
    for (int i = 0; i < 2; i++) begin
      raise(1, vec[i]);
      wait_ack(1, ca);
      wait_valid(cv);
      n_checks++;
      if (cv !== 4) begin n_fail++; $display("FAIL maxval_latency %h: got %0d expected 4", vec[i], cv); end
      n_checks++;
      if ({bus.res_div3, bus.res_invalid, bus.res_id} !== 3'b101) begin
        n_fail++;
        $display("FAIL maxval_result %h: got %b expected 101", vec[i],
                 {bus.res_div3, bus.res_invalid, bus.res_id});
      end
      accept();
    end
  endtask

  task automatic test_invalid();
    logic [15:0] vec [2] = '{16'h12A3, 16'hF000};
    int ca, cv;
    for (int i = 0; i < 2; i++) begin
      raise(0, vec[i]);
      wait_ack(0, ca);
      wait_valid(cv);
      n_checks++;
      if ({bus.res_div3, bus.res_invalid, bus.res_id} !== 3'b010) begin
        n_fail++;
        $display("FAIL invalid_result %h: got %b expected 010", vec[i],
                 {bus.res_div3, bus.res_invalid, bus.res_id});
      end
      accept();
    end
  endtask

  task automatic test_contention();
    int ca, cv;
    // Pointer fresh from reset: requester 0 first
    raise(0, 16'h0333);
    raise(1, 16'h0001);
    wait_ack(0, ca);
    n_checks++;
    if (ca !== 1) begin n_fail++; $display("FAIL cont_first_ack0: got %0d expected 1", ca); end
    wait_valid(cv);
    n_checks++;
    if ({bus.res_div3, bus.res_id} !== 2'b10) begin
      n_fail++;
      $display("FAIL cont_first_result: got %b expected 10", {bus.res_div3, bus.res_id});
    end
    accept();
    // Requester 1 still requesting: granted at the edge after acceptance
    wait_ack(1, ca);
    n_checks++;
    if (ca !== 1) begin n_fail++; $display("FAIL cont_second_ack1: got %0d expected 1", ca); end
    wait_valid(cv);
    n_checks++;
    if ({bus.res_div3, bus.res_id} !== 2'b01) begin
      n_fail++;
      $display("FAIL cont_second_result: got %b expected 01", {bus.res_div3, bus.res_id});
    end
    accept();
    // Both again: last grant was 1, so 0 wins
    raise(0, 16'h0333);
    raise(1, 16'h0001);
    wait_ack(0, ca);
    n_checks++;
    if (ca !== 1) begin n_fail++; $display("FAIL cont_third_ack0: got %0d expected 1", ca); end
    wait_valid(cv);
    n_checks++;
    if ({bus.res_div3, bus.res_id} !== 2'b10) begin
      n_fail++;
      $display("FAIL cont_third_result: got %b expected 10", {bus.res_div3, bus.res_id});
    end
    accept();
    wait_ack(1, ca);
    wait_valid(cv);
    n_checks++;
    if (bus.res_id !== 1'b1) begin n_fail++; $display("FAIL cont_drain_id: got %b expected 1", bus.res_id); end
    accept();
  endtask

  task automatic test_backpressure();
    int ca, cv;
    raise(0, 16'h1234);
    wait_ack(0, ca);
    wait_valid(cv);
    raise(1, 16'h9999);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.res_valid, bus.res_div3, bus.res_invalid, bus.res_id, busy, bus.ack1} !== 6'b100010) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d: got %b expected 100010", i,
                 {bus.res_valid, bus.res_div3, bus.res_invalid, bus.res_id, busy, bus.ack1});
      end
    end
    accept();
    n_checks++;
    if ({bus.res_valid, bus.ack1} !== 2'b00) begin
      n_fail++;
      $display("FAIL backpressure_accept: got %b expected 00", {bus.res_valid, bus.ack1});
    end
    wait_ack(1, ca);
    n_checks++;
    if (ca !== 1) begin n_fail++; $display("FAIL backpressure_ack1: got %0d expected 1", ca); end
    wait_valid(cv);
    n_checks++;
    if ({bus.res_div3, bus.res_id} !== 2'b11) begin
      n_fail++;
      $display("FAIL backpressure_next_result: got %b expected 11", {bus.res_div3, bus.res_id});
    end
    accept();
  endtask

  task automatic test_reset_in_run();
    int ca, cv;
    raise(0, 16'h1234);
    wait_ack(0, ca);
    @(negedge clk);  // digit 0 folded; now in the second digit cycle
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, bus.res_valid, bus.ack0, bus.res_id} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_in_run_outputs: got %b expected 0000",
               {busy, bus.res_valid, bus.ack0, bus.res_id});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({bus.res_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_in_run_no_result: got %b expected 00", {bus.res_valid, busy});
    end
    raise(0, 16'h0102);
    wait_ack(0, ca);
    wait_valid(cv);
    n_checks++;
    if ({bus.res_div3, bus.res_invalid, bus.res_id} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_in_run_fresh: got %b expected 100",
               {bus.res_div3, bus.res_invalid, bus.res_id});
    end
    accept();
  endtask

  initial begin
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_max_value();
    test_invalid();
    test_backpressure();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
